// File: rtl/draw_rect_ctl.sv
// draw_rect_ctl: frame-rate motion controller for the rectangle overlay.
// Tracks the mouse while idle. A click drops the rectangle, which falls
// under gravity and bounces on the floor with damping until it settles.
// Position and velocity only change on the frame tick, so the drawing
// stage always sees one coherent position for a whole active frame.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | top-left corner follows the mouse on each frame tick
// FALL  | velocity grows by G per frame, checked against the floor
// RISE  | rebound: climbs with velocity shrinking by G per frame
// STOP  | settled on the floor; position held until the next click
module draw_rect_ctl #(
  parameter int RECT_HEIGHT = 100,
  parameter int FLOOR_Y     = 600,
  parameter int G           = 1,
  parameter int VMAX        = 60,
  parameter int VMIN        = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        vblnk,
  input  logic [11:0] mouse_xpos,
  input  logic [11:0] mouse_ypos,
  input  logic        mouse_left,
  output logic [11:0] xpos,
  output logic [11:0] ypos
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FALL = 2'd1,
    RISE = 2'd2,
    STOP = 2'd3
  } state_t;

  localparam logic [12:0] FLOOR_TOP = 13'(FLOOR_Y - RECT_HEIGHT);
  localparam logic [8:0]  VMAX_9    = 9'(VMAX);
  localparam logic [7:0]  VMAX_8    = 8'(VMAX);
  localparam logic [8:0]  G_9       = 9'(G);
  localparam logic [7:0]  G_8       = 8'(G);
  localparam logic [7:0]  VMIN_8    = 8'(VMIN);

  state_t      state, state_next;
  logic [7:0]  vel, vel_next;
  logic [11:0] xpos_next, ypos_next;

  logic        vblnk_d;
  logic        tick_q;
  logic        mouse_left_d;
  logic        click;

  logic [8:0]  vel_inc;
  logic [7:0]  v1;
  logic [12:0] y1;
  logic [7:0]  rebound;
  logic        ceil_hit;
  logic [11:0] y_up;
  logic [7:0]  vel_dec;

  // The tick is registered so the update lands 2 clocks after vblnk rises;
  // the click edge is used combinationally so a held button fires once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vblnk_d      <= 1'b0;
      tick_q       <= 1'b0;
      mouse_left_d <= 1'b0;
    end else begin
      vblnk_d      <= vblnk;
      tick_q       <= vblnk & ~vblnk_d;
      mouse_left_d <= mouse_left;
    end
  end

  assign click = mouse_left & ~mouse_left_d;

  // Falling step: saturated velocity, then next top edge at 13 bits so a
  // drop near the bottom of the 12-bit range cannot wrap past the floor.
  assign vel_inc = {1'b0, vel} + G_9;
  assign v1      = (vel_inc > VMAX_9) ? VMAX_8 : vel_inc[7:0];
  assign y1      = {1'b0, ypos} + {5'b0, v1};
  assign rebound = v1 - {2'b0, v1[7:2]};

  // Rising step: clamp at the top of the screen rather than underflow.
  assign ceil_hit = ({4'b0, vel} > ypos);
  assign y_up     = ypos - {4'b0, vel};
  assign vel_dec  = (vel > G_8) ? (vel - G_8) : 8'd0;

  // State, velocity and position registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      vel   <= 8'd0;
      xpos  <= 12'd0;
      ypos  <= 12'd0;
    end else begin
      state <= state_next;
      vel   <= vel_next;
      xpos  <= xpos_next;
      ypos  <= ypos_next;
    end
  end

  // Next-state, velocity and position; everything holds by default.
  always_comb begin
    state_next = state;
    vel_next   = vel;
    xpos_next  = xpos;
    ypos_next  = ypos;
    case (state)
      IDLE: begin
        if (tick_q) begin
          xpos_next = mouse_xpos;
          ypos_next = mouse_ypos;
        end
        if (click) begin
          state_next = FALL;
          vel_next   = 8'd0;
        end
      end
      FALL: begin
        if (tick_q) begin
          if (y1 >= FLOOR_TOP) begin
            ypos_next = FLOOR_TOP[11:0];
            if (rebound < VMIN_8) begin
              state_next = STOP;
              vel_next   = 8'd0;
            end else begin
              state_next = RISE;
              vel_next   = rebound;
            end
          end else begin
            ypos_next = y1[11:0];
            vel_next  = v1;
          end
        end
      end
      RISE: begin
        if (tick_q) begin
          if (ceil_hit) begin
            ypos_next  = 12'd0;
            vel_next   = 8'd0;
            state_next = FALL;
          end else begin
            ypos_next = y_up;
            vel_next  = vel_dec;
            if (vel_dec == 8'd0) begin
              state_next = FALL;
            end
          end
        end
      end
      STOP: begin
        if (click) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
        vel_next   = 8'd0;
      end
    endcase
  end

endmodule

// File: tb/tb_draw_rect_ctl.sv
// Testbench for draw_rect_ctl: stimulus pushes the hand-derived position
// expected after each frame tick; a monitor pops and compares it when the
// DUT presents the update, and also checks the outputs held steady up to it.
module tb_draw_rect_ctl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        vblnk;
  logic [11:0] mouse_xpos;
  logic [11:0] mouse_ypos;
  logic        mouse_left;
  logic [11:0] xpos;
  logic [11:0] ypos;

  always #5 clk = ~clk;

  draw_rect_ctl dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .vblnk      (vblnk),
    .mouse_xpos (mouse_xpos),
    .mouse_ypos (mouse_ypos),
    .mouse_left (mouse_left),
    .xpos       (xpos),
    .ypos       (ypos)
  );

  int          n_vec = 0;
  int          n_bad = 0;
  logic [23:0] exp_q[$];
  logic [11:0] last_x = 12'd0;
  logic [11:0] last_y = 12'd0;
  logic        mon_prev = 1'b0;

  task automatic check(input string name, input logic [11:0] ax, input logic [11:0] ay,
                       input logic [11:0] ex, input logic [11:0] ey);
    n_vec++;
    if (ax !== ex || ay !== ey) begin
      n_bad++;
      $display("FAIL %s: got (%0d,%0d) want (%0d,%0d) at %0t", name, ax, ay, ex, ey, $time);
    end
  endtask

  // Monitor: on each vblnk rise, outputs must still hold one clock later,
  // then the next clock they must show the queued expected position.
  initial begin
    logic [23:0] e;
    forever begin
      @(posedge clk);
      if (vblnk && !mon_prev && rst_n) begin
        #1;
        check("hold", xpos, ypos, last_x, last_y);
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
          n_vec++;
          n_bad++;
          $display("FAIL underflow: update seen with no expected value at %0t", $time);
        end else begin
          e = exp_q.pop_front();
          check("tick", xpos, ypos, e[23:12], e[11:0]);
          last_x = e[23:12];
          last_y = e[11:0];
        end
      end
      mon_prev = vblnk;
    end
  end

  // One frame: vblnk high 3 clocks, low 6; optional click pulse while low.
  task automatic frame(input logic [11:0] ex, input logic [11:0] ey, input bit pulse);
    exp_q.push_back({ex, ey});
    vblnk = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    vblnk = 1'b0;
    if (pulse) begin
      mouse_left = 1'b1;
      @(posedge clk); #1;
      mouse_left = 1'b0;
    end
    repeat (6) begin @(posedge clk); #1; end
  endtask

  task automatic click_btn();
    mouse_left = 1'b1;
    @(posedge clk); #1;
    mouse_left = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic set_mouse(input logic [11:0] x, input logic [11:0] y);
    mouse_xpos = x;
    mouse_ypos = y;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int rv[8];
    int y;
    rv = '{18, 14, 11, 9, 7, 6, 5, 4};
    rst_n      = 1'b0;
    vblnk      = 1'b0;
    mouse_left = 1'b0;
    set_mouse(12'd300, 12'd200);
    repeat (3) begin @(posedge clk); #1; end
    vblnk = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
    check("reset", xpos, ypos, 12'd0, 12'd0);
    vblnk = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    rst_n = 1'b1;
    repeat (2) begin @(posedge clk); #1; end

    // Mouse tracking; mouse moves between ticks must not reach outputs early.
    frame(12'd300, 12'd200, 1'b0);
    set_mouse(12'd310, 12'd210);
    frame(12'd310, 12'd210, 1'b0);
    set_mouse(12'd300, 12'd200);
    frame(12'd300, 12'd200, 1'b0);

    // Drop with button held; extra clicks during fall/rise are ignored.
    mouse_left = 1'b1;
    @(posedge clk); #1;
    y = 200;
    for (int n = 1; n <= 24; n++) begin
      y += n;
      mouse_xpos = 12'(n * 7);
      frame(12'd300, 12'(y), n == 10);
      if (n == 5) mouse_left = 1'b0;
    end
    for (int i = 0; i < 8; i++) begin
      for (int v = rv[i]; v >= 1; v--) begin
        y -= v;
        frame(12'd300, 12'(y), (i == 1) && (v == 10));
      end
      for (int k = 1; k <= rv[i]; k++) begin
        y += k;
        frame(12'd300, 12'(y), 1'b0);
      end
    end
    repeat (3) frame(12'd300, 12'd500, 1'b0);

    // Click in STOP returns to tracking.
    click_btn();
    set_mouse(12'd40, 12'd77);
    frame(12'd40, 12'd77, 1'b0);

    // Drop below floor_top: clamp, rebound 1 < VMIN, settle.
    set_mouse(12'd40, 12'd550);
    frame(12'd40, 12'd550, 1'b0);
    click_btn();
    set_mouse(12'd90, 12'd10);
    frame(12'd40, 12'd500, 1'b0);
    frame(12'd40, 12'd500, 1'b0);

    // Drop one pixel above floor_top: first tick lands and settles.
    click_btn();
    set_mouse(12'd60, 12'd499);
    frame(12'd60, 12'd499, 1'b0);
    click_btn();
    frame(12'd60, 12'd500, 1'b0);
    set_mouse(12'd61, 12'd300);
    frame(12'd60, 12'd500, 1'b0);

    // Reset during rise.
    click_btn();
    set_mouse(12'd300, 12'd200);
    frame(12'd300, 12'd200, 1'b0);
    click_btn();
    y = 200;
    for (int n = 1; n <= 24; n++) begin
      y += n;
      frame(12'd300, 12'(y), 1'b0);
    end
    frame(12'd300, 12'd482, 1'b0);
    frame(12'd300, 12'd465, 1'b0);
    frame(12'd300, 12'd449, 1'b0);
    rst_n = 1'b0;
    #2;
    check("rst_async", xpos, ypos, 12'd0, 12'd0);
    @(posedge clk); #1;
    rst_n  = 1'b1;
    last_x = 12'd0;
    last_y = 12'd0;
    set_mouse(12'd123, 12'd45);
    frame(12'd123, 12'd45, 1'b0);
    click_btn();
    frame(12'd123, 12'd46, 1'b0);
    frame(12'd123, 12'd48, 1'b0);

    repeat (4) begin @(posedge clk); #1; end
    n_vec++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: %0d expected updates never seen, want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
